tt_sweep_checker: RTL
=====================

Name: tt_sweep_checker

Overview:
- Sequential test stage that sits upstream and downstream of one 4-input, 1-output combinational function block (inputs x0..x3, output y0).
- Drives x0..x3 through all 16 minterms in order and samples y0 for each, building the 16-bit truth table.
- Compares the table against an expected table and reports match, mismatch count and first failing minterm.
- Used to check each exact-synthesis network in hardware or emulation against its target function.

Parameters:
- SETTLE_CYCLES, 1, cycles each minterm is held before y0 is sampled; legal range 1..15.
- TT_W, 16, truth-table width; fixed at 16 (4 inputs), not overridable.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request to begin a sweep; sampled only in IDLE
- exp_tt  input  16  expected truth table; bit i = expected y0 for minterm i = {x3,x2,x1,x0}; latched on accepted start
- y0  input  1  output of the function under test
- x0  output  1  minterm bit 0 to the function under test
- x1  output  1  minterm bit 1
- x2  output  1  minterm bit 2
- x3  output  1  minterm bit 3
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse when results become valid
- tt  output  16  captured truth table
- match  output  1  1 when tt == latched exp_tt
- mismatch_count  output  5  popcount(tt ^ exp_tt), range 0..16
- first_mismatch  output  4  lowest minterm index with tt[i] != exp[i]; 0 when match=1

Behaviour:
- Reset (async assert, sync release) clears all outputs and state: x0..x3=0, busy=0, done=0, tt=0, match=0, mismatch_count=0, first_mismatch=0, FSM=IDLE, latched expected table=0.
- IDLE:
  - start=1: latch exp_tt, set idx=0, drive x={idx}, load settle counter with SETTLE_CYCLES, go to HOLD, busy=1.
  - start=0: stay in IDLE; outputs hold the last results.
- HOLD:
  - x3..x0 equal idx, registered, glitch-free.
  - Counter decrements each cycle; at 0, move to SAMPLE.
  - The minterm is stable for SETTLE_CYCLES full cycles before sampling.
- SAMPLE:
  - Capture y0 into tt[idx].
  - If bit differs from expected: increment mismatch_count; if this is the first mismatch, record idx in first_mismatch.
  - If idx==15: go to FINISH.
  - Else: idx+1, drive new x, reload counter, go to HOLD.
- FINISH:
  - Compute match = (mismatch_count==0); done=1 for exactly this cycle.
  - busy=0 from the next cycle; return to IDLE with x held at 4'hF.
- Latency: start accepted at cycle 0; done asserted at cycle 16*(SETTLE_CYCLES+1)+1. With the default this is cycle 33.
- tt, mismatch_count, first_mismatch are cleared on accepted start and are intermediate (not valid) while busy=1. match is held at 0 while busy.
- Start while busy: ignored, no restart, no error.
- Start in the same cycle as FINISH: ignored; a new start is required in IDLE.
- Change of exp_tt while busy: no effect; the latched copy is used.
- rst mid-sweep: immediate abort to the reset state; partial results discarded; no done pulse.
- mismatch_count saturates naturally at 16; no wrap is possible.
- y0 is treated as synchronous to clk. The settle window covers the combinational path; no synchroniser.

Test Plan:
- Model y0 = x0&x1, exp_tt=16'h8888, start -> done at cycle 33; tt=16'h8888, match=1, mismatch_count=0, first_mismatch=0.
- Model y0 = x0^x1^x2^x3, exp_tt=16'h6996 -> tt=16'h6996, match=1. Repeat with exp_tt=16'h6997 -> match=0, mismatch_count=1, first_mismatch=0.
- Model y0 = 0, exp_tt=16'hFFFF -> tt=0, mismatch_count=16, first_mismatch=0. Model y0 = x3, exp_tt=16'hFF01 -> mismatch_count=1, first_mismatch=0. Model y0 = x0&x1, exp_tt=16'h8808 -> mismatch_count=1, first_mismatch=7.
- SETTLE_CYCLES=3, model y0 = x2 registered through a 2-cycle delay -> tt=16'hF0F0, done at cycle 65. With SETTLE_CYCLES=1 the same model -> match=0 against 16'hF0F0.
- Pulse start at cycle 10 of a sweep; separately toggle exp_tt mid-sweep -> sweep unaffected, single done at cycle 33, results from the original exp_tt.
- Assert rst at cycle 20 of a sweep -> all outputs 0 the same cycle, no done. A fresh start after release completes normally in 33 cycles.

Source files
------------

// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table sweep of a 4-input combinational block.
// Each minterm is driven, held for SETTLE_CYCLES, sampled, and compared against a latched expected table.
module tt_sweep_checker #(
  parameter  int unsigned SETTLE_CYCLES = 1,
  localparam int unsigned TT_W          = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [TT_W-1:0] exp_tt,
  input  logic            y0,
  output logic            x0,
  output logic            x1,
  output logic            x2,
  output logic            x3,
  output logic            busy,
  output logic            done,
  output logic [TT_W-1:0] tt,
  output logic            match,
  output logic [4:0]      mismatch_count,
  output logic [3:0]      first_mismatch
);

  // state  | meaning
  // IDLE   | waiting for start, last results held on outputs
  // HOLD   | minterm r_idx driven, settle counter running
  // SAMPLE | y0 captured into tt[r_idx] and compared
  // FINISH | match valid, done pulse high, busy drops next cycle
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

  state_t          r_state;
  logic [3:0]      r_idx;
  logic [3:0]      r_x;
  logic [3:0]      r_cnt;
  logic [TT_W-1:0] r_exp;
  logic [TT_W-1:0] r_tt;
  logic [4:0]      r_mm_cnt;
  logic [3:0]      r_first;
  logic            r_match;
  logic            r_busy;
  logic            r_done;

  logic            w_bit_err;
  logic [4:0]      w_cnt_next;

  assign w_bit_err  = (y0 != r_exp[r_idx]);
  assign w_cnt_next = r_mm_cnt + {4'd0, w_bit_err};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_idx    <= 4'd0;
      r_x      <= 4'd0;
      r_cnt    <= 4'd0;
      r_exp    <= '0;
      r_tt     <= '0;
      r_mm_cnt <= 5'd0;
      r_first  <= 4'd0;
      r_match  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_exp    <= exp_tt;
            r_idx    <= 4'd0;
            r_x      <= 4'd0;
            r_cnt    <= SETTLE_LD;
            r_tt     <= '0;
            r_mm_cnt <= 5'd0;
            r_first  <= 4'd0;
            r_match  <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= HOLD;
          end
        end
        HOLD: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt <= 4'd1)
            r_state <= SAMPLE;
        end
        SAMPLE: begin
          r_tt[r_idx] <= y0;
          if (w_bit_err) begin
            r_mm_cnt <= w_cnt_next;
            // an empty count means no earlier minterm has failed
            if (r_mm_cnt == 5'd0)
              r_first <= r_idx;
          end
          if (r_idx == 4'hF) begin
            r_match <= (w_cnt_next == 5'd0);
            r_done  <= 1'b1;
            r_state <= FINISH;
          end else begin
            r_idx   <= r_idx + 4'd1;
            r_x     <= r_idx + 4'd1;
            r_cnt   <= SETTLE_LD;
            r_state <= HOLD;
          end
        end
        FINISH: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign x0             = r_x[0];
  assign x1             = r_x[1];
  assign x2             = r_x[2];
  assign x3             = r_x[3];
  assign busy           = r_busy;
  assign done           = r_done;
  assign tt             = r_tt;
  assign match          = r_match;
  assign mismatch_count = r_mm_cnt;
  assign first_mismatch = r_first;

endmodule
